// File: rtl/reservation_station_array_pkg.sv
// Shared types for the reservation station array.
//   register                : renamed source operand, either a value or the tag of
//                             the functional unit that will produce it
//   operation_specification : decoded operation held by an entry
//   e_functional_unit       : broadcast / producer tag
//   rs_entry_t              : architectural contents of one station entry
// Helpers: has_rs1/has_rs2 (which sources an opcode reads), src_tag, capture_src.
package reservation_station_array_pkg;

   localparam int XLEN = 32;
   localparam int FU_W = 2;

   typedef enum logic [1:0] {
      FU_ALU = 2'd0,
      FU_MUL = 2'd1,
      FU_MEM = 2'd2,
      FU_BR  = 2'd3
   } e_functional_unit;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_MUL  = 4'd2,
      OP_ADDI = 4'd3,
      OP_LUI  = 4'd4,
      OP_LW   = 4'd5,
      OP_SW   = 4'd6,
      OP_BEQ  = 4'd7
   } e_opcode;

   typedef struct packed {
      e_opcode    opcode;
      logic [4:0] rd;
   } operation_specification;

   // When is_virtual is set, the low FU_W bits of value hold the producer tag.
   typedef struct packed {
      logic            is_virtual;
      logic [XLEN-1:0] value;
   } register;

   typedef struct packed {
      logic                   valid;
      operation_specification op;
      register                j;
      register                k;
   } rs_entry_t;

   function automatic logic has_rs1(input operation_specification op);
      case (op.opcode)
         OP_LUI:  return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic has_rs2(input operation_specification op);
      case (op.opcode)
         OP_ADD, OP_SUB, OP_MUL, OP_SW, OP_BEQ: return 1'b1;
         default:                               return 1'b0;
      endcase
   endfunction

   function automatic e_functional_unit src_tag(input register src);
      return e_functional_unit'(src.value[FU_W-1:0]);
   endfunction

   // Resolve a source: absent sources are marked resolved, a virtual source
   // matching the current broadcast takes the broadcast value.
   function automatic register capture_src(input logic             needed,
                                           input register          src,
                                           input logic             bc_en,
                                           input e_functional_unit bc_rs,
                                           input logic [XLEN-1:0]  bc_data);
      register r;
      r = src;
      if (!needed) begin
         r.is_virtual = 1'b0;
      end else if (src.is_virtual && bc_en && (src_tag(src) == bc_rs)) begin
         r.is_virtual = 1'b0;
         r.value      = bc_data;
      end else begin
         r = src;
      end
      return r;
   endfunction

endpackage

// File: rtl/reservation_station_array_rs_entry.sv
// rs_entry: one reservation-station slot.
//   alloc            : write the issue request into this slot at the edge
//   issue_op/read1/2 : issue payload
//   bcast_*          : common-data-bus broadcast used for wakeup
//   free             : dispatch handshake selected this slot
//   valid/ready      : slot occupied / both sources resolved
//   op/j_value/k_value : stored operation and operand values
// rs_entry_checker: flags a broadcast that matches a source which was already
// resolved by a same-cycle broadcast at issue (duplicate producer result).
module rs_entry
   import reservation_station_array_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int RS_ID      = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   alloc,
   input  operation_specification issue_op,
   input  register                read1,
   input  register                read2,
   input  logic                   bcast_en,
   input  logic [DATA_WIDTH-1:0]  bcast_data,
   input  e_functional_unit       bcast_rs,
   input  logic                   free,
   output logic                   valid,
   output logic                   ready,
   output operation_specification op,
   output logic [DATA_WIDTH-1:0]  j_value,
   output logic [DATA_WIDTH-1:0]  k_value
);

   rs_entry_t       entry_r;
   logic [XLEN-1:0] bc_data_s;

   assign bc_data_s = XLEN'(bcast_data);

   // Slot storage: issue capture, dispatch release, broadcast wakeup.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry_r <= '0;
      end else if (alloc) begin
         entry_r.valid <= 1'b1;
         entry_r.op    <= issue_op;
         entry_r.j     <= capture_src(has_rs1(issue_op), read1, bcast_en, bcast_rs, bc_data_s);
         entry_r.k     <= capture_src(has_rs2(issue_op), read2, bcast_en, bcast_rs, bc_data_s);
      end else if (free) begin
         entry_r.valid <= 1'b0;
      end else if (entry_r.valid) begin
         entry_r.j <= capture_src(1'b1, entry_r.j, bcast_en, bcast_rs, bc_data_s);
         entry_r.k <= capture_src(1'b1, entry_r.k, bcast_en, bcast_rs, bc_data_s);
      end
   end

   assign valid   = entry_r.valid;
   assign ready   = entry_r.valid && !entry_r.j.is_virtual && !entry_r.k.is_virtual;
   assign op      = entry_r.op;
   assign j_value = DATA_WIDTH'(entry_r.j.value);
   assign k_value = DATA_WIDTH'(entry_r.k.value);

   rs_entry_checker #(.RS_ID(RS_ID)) u_chk (
      .clk      (clk),
      .rst_n    (rst_n),
      .alloc    (alloc),
      .issue_op (issue_op),
      .read1    (read1),
      .read2    (read2),
      .bcast_en (bcast_en),
      .bcast_rs (bcast_rs),
      .free     (free),
      .valid    (entry_r.valid)
   );

endmodule

module rs_entry_checker
   import reservation_station_array_pkg::*;
#(
   parameter int RS_ID = 0
) (
   input logic                   clk,
   input logic                   rst_n,
   input logic                   alloc,
   input operation_specification issue_op,
   input register                read1,
   input register                read2,
   input logic                   bcast_en,
   input e_functional_unit       bcast_rs,
   input logic                   free,
   input logic                   valid
);

   logic             j_early_r, k_early_r;
   e_functional_unit j_tag_r, k_tag_r;

   // Remember which sources were woken by the broadcast in their issue cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         j_early_r <= 1'b0;
         k_early_r <= 1'b0;
         j_tag_r   <= FU_ALU;
         k_tag_r   <= FU_ALU;
      end else if (alloc) begin
         j_early_r <= has_rs1(issue_op) && read1.is_virtual && bcast_en && (src_tag(read1) == bcast_rs);
         k_early_r <= has_rs2(issue_op) && read2.is_virtual && bcast_en && (src_tag(read2) == bcast_rs);
         j_tag_r   <= src_tag(read1);
         k_tag_r   <= src_tag(read2);
      end else if (free) begin
         j_early_r <= 1'b0;
         k_early_r <= 1'b0;
      end
   end

   a_no_rebroadcast: assert property (@(posedge clk) disable iff (!rst_n)
      !(valid && bcast_en && ((j_early_r && (j_tag_r == bcast_rs)) || (k_early_r && (k_tag_r == bcast_rs)))))
      else $error("rs %0d: broadcast tag %0d matches a source resolved at issue", RS_ID, bcast_rs);

endmodule

// File: rtl/reservation_station_array.sv
// reservation_station_array: DEPTH-entry reservation station for one unit.
//   clk, rst_n                        : clock, async active-low reset
//   issue_en_i/issue_op_i/read*_value_i : issue request, full_o back-pressure
//   bcast_en_i/bcast_data_i/bcast_rs_i  : CDB broadcast
//   disp_valid_o/disp_ready_i/disp_*   : dispatch handshake and selected entry
//   count_o                             : number of occupied entries
// Macro RS_AGE_ORDER_EN: defined -> oldest-ready selection via per-entry age
// counters; undefined -> lowest-index ready selection, no age storage.
module reservation_station_array
   import reservation_station_array_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int RS_ID      = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         issue_en_i,
   input  operation_specification       issue_op_i,
   input  register                      read1_value_i,
   input  register                      read2_value_i,
   output logic                         full_o,
   input  logic                         bcast_en_i,
   input  logic [DATA_WIDTH-1:0]        bcast_data_i,
   input  e_functional_unit             bcast_rs_i,
   output logic                         disp_valid_o,
   input  logic                         disp_ready_i,
   output operation_specification       disp_op_o,
   output logic [DATA_WIDTH-1:0]        op1_value_o,
   output logic [DATA_WIDTH-1:0]        op2_value_o,
   output logic [$clog2(DEPTH)-1:0]     disp_idx_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0]       valid_s, ready_s, alloc_s, free_s;
   operation_specification op_s      [DEPTH];
   logic [DATA_WIDTH-1:0]  j_value_s [DEPTH];
   logic [DATA_WIDTH-1:0]  k_value_s [DEPTH];
   logic [IDX_W-1:0]       alloc_idx_s, sel_idx_s;
   logic                   issue_acc_s, disp_fire_s;
   logic [CNT_W-1:0]       count_r;

   // full_o looks only at registered valid bits, so a slot freed this cycle is not reused.
   assign full_o       = &valid_s;
   assign issue_acc_s  = issue_en_i && !full_o;
   assign disp_valid_o = |ready_s;
   assign disp_fire_s  = disp_valid_o && disp_ready_i;

   // Lowest-index free slot.
   always_comb begin
      alloc_idx_s = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         alloc_idx_s = valid_s[i] ? alloc_idx_s : IDX_W'(i);
      end
   end

   // One-hot issue and release strobes for the slots.
   always_comb begin
      alloc_s = '0;
      free_s  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         alloc_s[i] = issue_acc_s && (alloc_idx_s == IDX_W'(i));
         free_s[i]  = disp_fire_s && (sel_idx_s == IDX_W'(i));
      end
   end

`ifdef RS_AGE_ORDER_EN
   logic [IDX_W-1:0] age_r      [DEPTH];
   logic [IDX_W-1:0] age_next_s [DEPTH];
   logic [IDX_W-1:0] best_age_s;
   logic             found_s;

   // Oldest ready slot: ages are a dense permutation, so the largest age wins.
   always_comb begin
      sel_idx_s  = '0;
      best_age_s = '0;
      found_s    = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ready_s[i] && (!found_s || (age_r[i] > best_age_s))) begin
            sel_idx_s  = IDX_W'(i);
            best_age_s = age_r[i];
            found_s    = 1'b1;
         end else begin
            found_s    = found_s;
         end
      end
   end

   // New entry gets age 0; survivors age by one per issue and close the gap left by a release.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         age_next_s[i] = age_r[i];
         if (alloc_s[i]) begin
            age_next_s[i] = '0;
         end else if (valid_s[i]) begin
            age_next_s[i] = age_r[i] + IDX_W'(issue_acc_s)
                          - IDX_W'(disp_fire_s && (age_r[i] > age_r[sel_idx_s]));
         end else begin
            age_next_s[i] = age_r[i];
         end
      end
   end

   // Age counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) age_r[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) age_r[i] <= age_next_s[i];
      end
   end
`else
   // Lowest-index ready slot.
   always_comb begin
      sel_idx_s = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         sel_idx_s = ready_s[i] ? IDX_W'(i) : sel_idx_s;
      end
   end
`endif

   // Occupancy counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= '0;
      end else begin
         case ({issue_acc_s, disp_fire_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign count_o     = count_r;
   assign disp_op_o   = op_s[sel_idx_s];
   assign op1_value_o = j_value_s[sel_idx_s];
   assign op2_value_o = k_value_s[sel_idx_s];
   assign disp_idx_o  = sel_idx_s;

   for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      rs_entry #(.DATA_WIDTH(DATA_WIDTH), .RS_ID(RS_ID)) u_entry (
         .clk        (clk),
         .rst_n      (rst_n),
         .alloc      (alloc_s[g]),
         .issue_op   (issue_op_i),
         .read1      (read1_value_i),
         .read2      (read2_value_i),
         .bcast_en   (bcast_en_i),
         .bcast_data (bcast_data_i),
         .bcast_rs   (bcast_rs_i),
         .free       (free_s[g]),
         .valid      (valid_s[g]),
         .ready      (ready_s[g]),
         .op         (op_s[g]),
         .j_value    (j_value_s[g]),
         .k_value    (k_value_s[g])
      );
   end

endmodule

// File: tb/tb_reservation_station_array.sv
// Testbench for reservation_station_array (DEPTH=4, DATA_WIDTH=32).
// A driver applies directed then random cycles; a reference model of the
// station (issue order numbers, tag lists) predicts each cycle's status and
// any dispatch into queues; a monitor compares DUT outputs against them.
// Honors RS_AGE_ORDER_EN the same way the design does.
module tb_reservation_station_array;
   import reservation_station_array_pkg::*;

   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   issue_en_i = 1'b0;
   operation_specification issue_op_i = '0;
   register                read1_value_i = '0, read2_value_i = '0;
   logic                   full_o;
   logic                   bcast_en_i = 1'b0;
   logic [DW-1:0]          bcast_data_i = '0;
   e_functional_unit       bcast_rs_i = FU_ALU;
   logic                   disp_valid_o;
   logic                   disp_ready_i = 1'b0;
   operation_specification disp_op_o;
   logic [DW-1:0]          op1_value_o, op2_value_o;
   logic [1:0]             disp_idx_o;
   logic [2:0]             count_o;

   always #5 clk = ~clk;

   reservation_station_array #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .RS_ID(0)) dut (
      .clk(clk), .rst_n(rst_n), .issue_en_i(issue_en_i), .issue_op_i(issue_op_i),
      .read1_value_i(read1_value_i), .read2_value_i(read2_value_i), .full_o(full_o),
      .bcast_en_i(bcast_en_i), .bcast_data_i(bcast_data_i), .bcast_rs_i(bcast_rs_i),
      .disp_valid_o(disp_valid_o), .disp_ready_i(disp_ready_i), .disp_op_o(disp_op_o),
      .op1_value_o(op1_value_o), .op2_value_o(op2_value_o), .disp_idx_o(disp_idx_o),
      .count_o(count_o)
   );

   // reference model state
   bit                     m_valid [DEPTH];
   operation_specification m_op    [DEPTH];
   bit                     m_jv [DEPTH], m_kv [DEPTH], m_jneed [DEPTH], m_kneed [DEPTH];
   logic [1:0]             m_jtag [DEPTH], m_ktag [DEPTH];
   logic [31:0]            m_jval [DEPTH], m_kval [DEPTH];
   int                     m_seq [DEPTH];
   int                     seq_ctr = 0;

   typedef struct {
      operation_specification op;
      logic [31:0] v1, v2;
      bit need1, need2;
      int idx;
   } disp_t;
   typedef struct { bit dv; bit full; int cnt; } stat_t;
   disp_t exp_q[$];
   stat_t stat_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endfunction

   function automatic bit tb_needs1(input e_opcode o);
      return o != OP_LUI;
   endfunction
   function automatic bit tb_needs2(input e_opcode o);
      return o inside {OP_ADD, OP_SUB, OP_MUL, OP_SW, OP_BEQ};
   endfunction

   function automatic register nv(input logic [31:0] v);
      register r; r.is_virtual = 1'b0; r.value = v; return r;
   endfunction
   function automatic register vt(input e_functional_unit t);
      register r; r.is_virtual = 1'b1; r.value = {30'd0, t}; return r;
   endfunction

   function automatic void res_src(input bit need, input register r, input bit be,
                                   input logic [1:0] brs, input logic [31:0] bd,
                                   output bit v, output logic [1:0] tag, output logic [31:0] val);
      v = 1'b0; tag = r.value[1:0]; val = r.value;
      if (need && r.is_virtual) begin
         if (be && (r.value[1:0] == brs)) val = bd;
         else v = 1'b1;
      end
   endfunction

   // One clock of stimulus: drive inputs, predict outputs, advance the model.
   task automatic drive(input bit ie, input operation_specification op, input register r1,
                        input register r2, input bit be, input e_functional_unit brs,
                        input logic [31:0] bd, input bit rdy);
      int sel, cnt, free_idx; bit any, full; disp_t d; stat_t s;
      @(negedge clk);
      issue_en_i = ie; issue_op_i = op; read1_value_i = r1; read2_value_i = r2;
      bcast_en_i = be; bcast_rs_i = brs; bcast_data_i = bd; disp_ready_i = rdy;
      full = 1'b1; cnt = 0; any = 1'b0; sel = 0; free_idx = 0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (m_valid[i]) cnt++;
         else begin full = 1'b0; free_idx = i; end
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (m_valid[i] && !m_jv[i] && !m_kv[i]) begin
`ifdef RS_AGE_ORDER_EN
            if (!any || m_seq[i] < m_seq[sel]) sel = i;
`else
            if (!any) sel = i;
`endif
            any = 1'b1;
         end
      end
      s.dv = any; s.full = full; s.cnt = cnt;
      stat_q.push_back(s);
      if (any && rdy) begin
         d.op = m_op[sel]; d.v1 = m_jval[sel]; d.v2 = m_kval[sel];
         d.need1 = m_jneed[sel]; d.need2 = m_kneed[sel]; d.idx = sel;
         exp_q.push_back(d);
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (m_valid[i] && be && m_jv[i] && m_jtag[i] == brs) begin m_jv[i] = 1'b0; m_jval[i] = bd; end
         if (m_valid[i] && be && m_kv[i] && m_ktag[i] == brs) begin m_kv[i] = 1'b0; m_kval[i] = bd; end
      end
      if (any && rdy) m_valid[sel] = 1'b0;
      if (ie && !full) begin
         m_valid[free_idx] = 1'b1;
         m_op[free_idx]    = op;
         m_seq[free_idx]   = seq_ctr++;
         m_jneed[free_idx] = tb_needs1(op.opcode);
         m_kneed[free_idx] = tb_needs2(op.opcode);
         res_src(m_jneed[free_idx], r1, be, brs, bd, m_jv[free_idx], m_jtag[free_idx], m_jval[free_idx]);
         res_src(m_kneed[free_idx], r2, be, brs, bd, m_kv[free_idx], m_ktag[free_idx], m_kval[free_idx]);
      end
   endtask

   task automatic idle(input bit rdy);
      drive(1'b0, '0, nv(32'd0), nv(32'd0), 1'b0, FU_ALU, 32'd0, rdy);
   endtask

   task automatic mid_reset();
      stat_t s;
      @(negedge clk);
      issue_en_i = 1'b0; bcast_en_i = 1'b0; disp_ready_i = 1'b1;
      rst_n = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      s.dv = 1'b0; s.full = 1'b0; s.cnt = 0;
      stat_q.push_back(s);
      #1;
      check("midreset_disp_valid", disp_valid_o, 1'b0);
      check("midreset_count", count_o, 3'd0);
      @(negedge clk);
      rst_n = 1'b1;
      disp_ready_i = 1'b0;
   endtask

   function automatic register rand_src(input bit be, input e_functional_unit brs);
      logic [1:0] t;
      if ($urandom_range(0, 1) == 0) return nv($urandom);
      t = 2'($urandom_range(0, 3));
      if (be && t == brs) t = t + 2'd1;
      return vt(e_functional_unit'(t));
   endfunction

   // Monitor: per-cycle status and every dispatch handshake.
   initial begin
      stat_t s; disp_t d;
      forever begin
         @(negedge clk); #2;
         if (stat_q.size() > 0) begin
            s = stat_q.pop_front();
            check("disp_valid", disp_valid_o, s.dv);
            check("full", full_o, s.full);
            check("count", count_o, s.cnt);
         end
         if (disp_valid_o && disp_ready_i) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_dispatch: got idx %0d expected no dispatch at %0t", disp_idx_o, $time);
            end else begin
               d = exp_q.pop_front();
               check("disp_idx", disp_idx_o, d.idx);
               check("disp_op", disp_op_o, d.op);
               if (d.need1) check("op1_value", op1_value_o, d.v1);
               if (d.need2) check("op2_value", op2_value_o, d.v2);
            end
         end
      end
   end

   initial begin
      operation_specification op_add, op_mul, op_addi;
      operation_specification rop;
      bit be;
      e_functional_unit brs;
      op_add.opcode = OP_ADD; op_add.rd = 5'd1;
      op_mul.opcode = OP_MUL; op_mul.rd = 5'd2;
      op_addi.opcode = OP_ADDI; op_addi.rd = 5'd3;

      repeat (2) @(negedge clk);
      #1;
      check("reset_disp_valid", disp_valid_o, 1'b0);
      check("reset_full", full_o, 1'b0);
      check("reset_count", count_o, 3'd0);
      rst_n = 1'b1;

      // both sources ready at issue
      drive(1'b1, op_add, nv(32'd5), nv(32'd7), 1'b0, FU_ALU, 32'd0, 1'b0);
      idle(1'b1);
      idle(1'b0);

      // virtual source woken by the broadcast in its issue cycle
      drive(1'b1, op_add, vt(FU_ALU), nv(32'd3), 1'b1, FU_ALU, 32'h2A, 1'b0);
      idle(1'b1);
      idle(1'b0);

      // fill with entries waiting on MUL, fifth issue ignored, then wake all
      for (int i = 0; i < 4; i++) drive(1'b1, op_mul, vt(FU_MUL), vt(FU_MUL), 1'b0, FU_ALU, 32'd0, 1'b0);
      drive(1'b1, op_mul, nv(32'd1), nv(32'd1), 1'b0, FU_ALU, 32'd0, 1'b1);
      drive(1'b0, op_mul, nv(32'd0), nv(32'd0), 1'b1, FU_MUL, 32'd9, 1'b1);
      for (int i = 0; i < 5; i++) idle(1'b1);

      // younger entry in the lower slot: policy decides who goes first
      drive(1'b1, op_addi, nv(32'd100), nv(32'd0), 1'b0, FU_ALU, 32'd0, 1'b0);
      drive(1'b1, op_add, nv(32'd11), nv(32'd12), 1'b0, FU_ALU, 32'd0, 1'b0);
      idle(1'b1);
      drive(1'b1, op_add, vt(FU_MEM), nv(32'd13), 1'b0, FU_ALU, 32'd0, 1'b0);
      drive(1'b0, op_add, nv(32'd0), nv(32'd0), 1'b1, FU_MEM, 32'h11, 1'b0);
      idle(1'b1);
      idle(1'b1);
      idle(1'b0);

      // full array, dispatch and issue in the same cycle
      for (int i = 0; i < 4; i++) drive(1'b1, op_add, nv(32'(i)), nv(32'(i + 20)), 1'b0, FU_ALU, 32'd0, 1'b0);
      drive(1'b1, op_mul, nv(32'd77), nv(32'd78), 1'b0, FU_ALU, 32'd0, 1'b1);
      idle(1'b0);
      for (int i = 0; i < 4; i++) idle(1'b1);

      // reset with three entries in flight
      for (int i = 0; i < 3; i++) drive(1'b1, op_add, nv(32'(i + 40)), nv(32'd1), 1'b0, FU_ALU, 32'd0, 1'b0);
      mid_reset();
      idle(1'b1);

      // random traffic
      for (int c = 0; c < 600; c++) begin
         rop.opcode = e_opcode'($urandom_range(0, 7));
         rop.rd     = 5'($urandom);
         be  = ($urandom_range(0, 1) == 1);
         brs = e_functional_unit'($urandom_range(0, 3));
         drive($urandom_range(0, 9) < 6, rop, rand_src(be, brs), rand_src(be, brs),
               be, brs, $urandom, $urandom_range(0, 1) == 1);
      end

      // drain: cycle through every tag with dispatch always ready
      for (int c = 0; c < 24; c++)
         drive(1'b0, '0, nv(32'd0), nv(32'd0), 1'b1, e_functional_unit'(c % 4), $urandom, 1'b1);
      idle(1'b0);
      idle(1'b0);

      @(negedge clk); #3;
      check("exp_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
